// File: rtl/armored_tx_pkg.sv
// Shared encodings for the armored TX reset sequencer and the encoder-side monitors.
package armored_tx_pkg;
    localparam int SEQ_W = 2;

    localparam logic [SEQ_W-1:0] SEQ_PD   = 2'd0;
    localparam logic [SEQ_W-1:0] SEQ_LOCK = 2'd1;
    localparam logic [SEQ_W-1:0] SEQ_TXA  = 2'd2;
    localparam logic [SEQ_W-1:0] SEQ_RUN  = 2'd3;
endpackage

// File: rtl/armored_sat_cnt.sv
// Saturating event counter; holds at all-ones once full.
module armored_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sync_regs.sv
// Two-flop synchroniser for quasi-static level inputs crossing into the local clock.
module sync_regs #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/armored_tx_reset_seq.sv
// TX reset sequencer: PLL powerdown -> lock debounce -> TX analog release -> TX digital release,
// with lock timeout/retry, filtered loss-of-lock detection and software restart.
module armored_tx_reset_seq
    import armored_tx_pkg::*;
#(
    parameter int NUM_PLLS     = 1,
    parameter int RST_CNTR     = 16,
    parameter int LOCK_TO_BITS = 20,
    parameter int LOSS_FILT    = 8,
    parameter int STAT_W       = 8
) (
    input  logic              clk100,
    input  logic              rst100,
    input  logic [NUM_PLLS-1:0] pll_locked,
    input  logic [NUM_PLLS-1:0] pll_enable,
    input  logic              restart,
    output logic              pll_powerdown,
    output logic              rst_txa,
    output logic              rst_txd,
    output logic              tx_ready,
    output logic [SEQ_W-1:0]  seq_state,
    output logic [STAT_W-1:0] retry_cnt,
    output logic [STAT_W-1:0] loss_cnt,
    output logic              loss_sticky
);
    localparam logic [7:0] LF_LAST = 8'(LOSS_FILT - 1);

    logic [NUM_PLLS-1:0]     lk_sync;
    logic                    all_lk;
    logic [SEQ_W-1:0]        st, nxt;
    logic [RST_CNTR-1:0]     cnt;
    logic [LOCK_TO_BITS-1:0] to;
    logic [7:0]              lf;
    logic                    loss, retry_inc, loss_inc, entry, in_svc;

    sync_regs #(.WIDTH(NUM_PLLS)) u_sync (
        .clk (clk100),
        .rst (rst100),
        .d   (pll_locked),
        .q   (lk_sync)
    );

    // Disabled PLLs count as locked, so an all-zero mask reads as locked.
    assign all_lk = &(lk_sync | ~pll_enable);
    assign in_svc = (st == SEQ_TXA) || (st == SEQ_RUN);
    assign loss   = in_svc && !all_lk && (lf == LF_LAST);

    always_comb begin
        nxt       = st;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        if (restart) begin
            nxt = SEQ_PD;
        end else begin
            case (st)
                SEQ_PD:   if (cnt == '1) nxt = SEQ_LOCK;
                SEQ_LOCK: begin
                    // A completed debounce beats a simultaneous timeout.
                    if (all_lk && cnt == '1) begin
                        nxt = SEQ_TXA;
                    end else if (to == '1) begin
                        nxt       = SEQ_PD;
                        retry_inc = 1'b1;
                    end
                end
                SEQ_TXA: begin
                    if (loss) begin
                        nxt      = SEQ_PD;
                        loss_inc = 1'b1;
                    end else if (cnt == '1) begin
                        nxt = SEQ_RUN;
                    end
                end
                default: begin
                    if (loss) begin
                        nxt      = SEQ_PD;
                        loss_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    // Restart while already in PD still re-arms the stage timer.
    assign entry = (nxt != st) || restart;

    always_ff @(posedge clk100 or posedge rst100) begin
        if (rst100) begin
            st            <= SEQ_PD;
            cnt           <= '0;
            to            <= '0;
            lf            <= '0;
            loss_sticky   <= 1'b0;
            pll_powerdown <= 1'b1;
            rst_txa       <= 1'b1;
            rst_txd       <= 1'b1;
            tx_ready      <= 1'b0;
        end else begin
            st <= nxt;

            if (entry)
                cnt <= '0;
            else if (st == SEQ_LOCK && !all_lk)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (entry)
                to <= '0;
            else if (st == SEQ_LOCK)
                to <= to + 1'b1;

            if (entry || !in_svc || all_lk)
                lf <= '0;
            else
                lf <= lf + 1'b1;

            if (loss_inc)
                loss_sticky <= 1'b1;

            // Outputs are decoded from the next state so they flip on the same edge as st.
            pll_powerdown <= (nxt == SEQ_PD);
            rst_txa       <= (nxt == SEQ_PD) || (nxt == SEQ_LOCK);
            rst_txd       <= (nxt != SEQ_RUN);
            tx_ready      <= (nxt == SEQ_RUN);
        end
    end

    assign seq_state = st;

    armored_sat_cnt #(.W(STAT_W)) u_retry (
        .clk (clk100),
        .rst (rst100),
        .inc (retry_inc),
        .cnt (retry_cnt)
    );

    armored_sat_cnt #(.W(STAT_W)) u_loss (
        .clk (clk100),
        .rst (rst100),
        .inc (loss_inc),
        .cnt (loss_cnt)
    );
endmodule

// File: tb/tb_armored_tx_reset_seq.sv
// Directed bench for armored_tx_reset_seq with short stage timers.
module tb_armored_tx_reset_seq;
    logic       clk100 = 1'b0;
    logic       rst100;
    logic [2:0] pll_locked;
    logic [2:0] pll_enable;
    logic       restart;
    logic       pll_powerdown, rst_txa, rst_txd, tx_ready, loss_sticky;
    logic [1:0] seq_state;
    logic [3:0] retry_cnt, loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit toggle_en = 1'b0;
    int n;

    armored_tx_reset_seq #(
        .NUM_PLLS(3), .RST_CNTR(4), .LOCK_TO_BITS(7), .LOSS_FILT(3), .STAT_W(4)
    ) dut (
        .clk100        (clk100),
        .rst100        (rst100),
        .pll_locked    (pll_locked),
        .pll_enable    (pll_enable),
        .restart       (restart),
        .pll_powerdown (pll_powerdown),
        .rst_txa       (rst_txa),
        .rst_txd       (rst_txd),
        .tx_ready      (tx_ready),
        .seq_state     (seq_state),
        .retry_cnt     (retry_cnt),
        .loss_cnt      (loss_cnt),
        .loss_sticky   (loss_sticky)
    );

    always #5 clk100 = ~clk100;

    task automatic tick();
        @(posedge clk100);
        #1;
        cyc++;
        if (toggle_en) pll_locked[2] = (cyc % 10 != 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges until seq_state equals s, bounded by budget.
    task automatic wait_state(input logic [1:0] s, input int budget, output int cnt);
        cnt = 0;
        while (seq_state !== s && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst100 = 1'b1; restart = 1'b0;
        pll_locked = 3'b111; pll_enable = 3'b111;

        // 1. reset state and a clean sequence
        repeat (3) tick();
        chk("rst_state", seq_state, 0);
        chk("rst_pd", pll_powerdown, 1);
        chk("rst_txa", rst_txa, 1);
        chk("rst_txd", rst_txd, 1);
        chk("rst_ready", tx_ready, 0);
        chk("rst_cnts", {retry_cnt, loss_cnt, 3'b0, loss_sticky}, 0);
        rst100 = 1'b0;
        wait_state(2'd1, 100, n); chk("t1_pd_len", n, 16);
        chk("t1_pd_low", pll_powerdown, 0);
        chk("t1_txa_hi", rst_txa, 1);
        wait_state(2'd2, 100, n); chk("t1_lock_len", n, 16);
        chk("t1_txa_low", rst_txa, 0);
        chk("t1_txd_hi", rst_txd, 1);
        wait_state(2'd3, 100, n); chk("t1_txa_len", n, 16);
        chk("t1_txd_low", rst_txd, 0);
        chk("t1_ready", tx_ready, 1);

        // 2. missing lock on an enabled PLL times out, then masking it lets the sequence finish
        pll_locked = 3'b011; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t2_restart_pd", seq_state, 0);
        chk("t2_ready_drop", tx_ready, 0);
        wait_state(2'd1, 100, n); chk("t2_pd_len", n, 16);
        wait_state(2'd0, 300, n); chk("t2_timeout", n, 128);
        chk("t2_retry", retry_cnt, 1);
        chk("t2_pd_reassert", {pll_powerdown, rst_txa, rst_txd}, 3'b111);
        wait_state(2'd1, 100, n); chk("t2_pd_len2", n, 16);
        pll_enable = 3'b011;
        wait_state(2'd2, 300, n); chk("t2_lock_len", n, 16);
        wait_state(2'd3, 100, n); chk("t2_txa_len", n, 16);
        chk("t2_counts", {retry_cnt, loss_cnt}, 8'h10);

        // 3. loss filter: 2-cycle glitch ignored, 3-cycle drop declares loss
        pll_locked = 3'b010;
        repeat (2) tick();
        pll_locked = 3'b011;
        repeat (4) tick();
        chk("t3_glitch_run", seq_state, 3);
        chk("t3_glitch_loss", loss_cnt, 0);
        pll_locked = 3'b010;
        repeat (3) tick();
        pll_locked = 3'b011;
        repeat (3) tick();
        chk("t3_loss_state", seq_state, 0);
        chk("t3_loss_ready", tx_ready, 0);
        chk("t3_loss_resets", {pll_powerdown, rst_txa, rst_txd}, 3'b111);
        chk("t3_loss_cnt", loss_cnt, 1);
        chk("t3_sticky", loss_sticky, 1);
        chk("t3_retry", retry_cnt, 1);

        // 4. periodic lock glitch keeps debounce from completing; retries saturate
        pll_enable = 3'b111; pll_locked = 3'b111; toggle_en = 1'b1;
        wait_state(2'd1, 100, n);
        wait_state(2'd0, 300, n); chk("t4_timeout", n, 128);
        chk("t4_retry2", retry_cnt, 2);
        for (int i = 0; i < 19; i++) begin
            wait_state(2'd1, 100, n);
            wait_state(2'd0, 300, n);
        end
        chk("t4_last_timeout", n, 128);
        chk("t4_retry_sat", retry_cnt, 4'hF);
        chk("t4_loss_kept", loss_cnt, 1);
        toggle_en = 1'b0; pll_locked = 3'b111;

        // 5. restart in TXA; counters unchanged; full sequence again
        wait_state(2'd1, 100, n); chk("t5_pd_len", n, 16);
        wait_state(2'd2, 100, n); chk("t5_lock_len", n, 16);
        repeat (3) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_restart_state", seq_state, 0);
        chk("t5_restart_txa", rst_txa, 1);
        chk("t5_restart_pd", pll_powerdown, 1);
        chk("t5_counts", {retry_cnt, loss_cnt}, 8'hF1);
        wait_state(2'd1, 100, n); chk("t5_pd_len2", n, 16);
        wait_state(2'd2, 100, n); chk("t5_lock_len2", n, 16);
        wait_state(2'd3, 100, n); chk("t5_txa_len2", n, 16);
        chk("t5_ready", tx_ready, 1);

        // 6. asynchronous reset mid-cycle in RUN
        repeat (2) tick();
        #3 rst100 = 1'b1;
        #1;
        chk("t6_state", seq_state, 0);
        chk("t6_outs", {pll_powerdown, rst_txa, rst_txd, tx_ready}, 4'b1110);
        chk("t6_cnts", {retry_cnt, loss_cnt}, 8'h00);
        chk("t6_sticky", loss_sticky, 0);
        tick();
        rst100 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
